// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, control/INT sub-codes and the
// interrupt controller state type.
package proc_pkg;

    localparam logic [3:0] OP_ALU     = 4'b0000;
    localparam logic [3:0] OP_LOAD    = 4'b1000;
    localparam logic [3:0] OP_STORE   = 4'b1001;
    localparam logic [3:0] OP_BRANCH  = 4'b1100;
    localparam logic [3:0] OP_JUMP    = 4'b1101;
    localparam logic [3:0] OP_INT     = 4'b1110;
    localparam logic [3:0] OP_CONTROL = 4'b1111;

    localparam logic [1:0] INT_DISABLE = 2'b00;
    localparam logic [1:0] INT_ENABLE  = 2'b01;
    localparam logic [1:0] INT_TRIGGER = 2'b10;
    localparam logic [1:0] INT_NOP     = 2'b11;

    localparam logic [11:0] CTRL_RETURN = 12'h000;
    localparam logic [11:0] CTRL_STC    = 12'h001;
    localparam logic [11:0] CTRL_STB    = 12'h002;
    localparam logic [11:0] CTRL_RESET  = 12'h003;
    localparam logic [11:0] CTRL_HALT   = 12'h004;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ISR  = 1'b1
    } irq_state_t;

    // Vector address wraps modulo 2^16.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [2:0]  id);
        logic [15:0] off;
        off = stride * {13'b0, id};
        return base + off;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set index of the pending vector wins.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [2:0]         id,
    output logic [NUM_IRQ-1:0] grant
);

    always_comb begin
        valid = |pending;
        id    = '0;
        grant = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                id       = 3'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller and PC-redirect sequencer for the 16-bit core.
// Optional nesting (2-level return stack) with `define IRQ_NEST_EN.
//
// state | meaning
// IDLE  | running normal code; may vector to an IRQ at a clk_en boundary
// ISR   | servicing active_irq; RETURN restores the saved PC and enable
module irq_controller
    import proc_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter int          VECTOR_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_en,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               int_cmd,
    input  logic [1:0]         int_mode,
    input  logic [2:0]         int_sel,
    input  logic               return_cmd,
    input  logic [15:0]        pc_next_in,
    output logic               vector_taken,
    output logic [15:0]        irq_vector_pc,
    output logic               return_taken,
    output logic [15:0]        return_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               int_enabled,
    output logic               in_isr,
    output logic [2:0]         active_irq
);

    irq_state_t         state_q, state_d;
    logic               int_enabled_q, int_enabled_d;
    logic [NUM_IRQ-1:0] sw_pending_q, sw_pending_d;
    logic [15:0]        saved_pc_q, saved_pc_d;
    logic               saved_en_q, saved_en_d;
    logic [2:0]         active_irq_q, active_irq_d;

`ifdef IRQ_NEST_EN
    logic               nest_q, nest_d;
    logic [15:0]        stk_pc_q, stk_pc_d;
    logic               stk_en_q, stk_en_d;
    logic [2:0]         stk_irq_q, stk_irq_d;
`endif

    logic [NUM_IRQ-1:0] pending;
    logic               win_valid;
    logic [2:0]         win_id;
    logic [NUM_IRQ-1:0] win_grant;
    logic               int_disable, int_enable, int_trigger;
    logic [NUM_IRQ-1:0] trig_mask;
    logic               can_vector;

    assign pending = irq_req | sw_pending_q;

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .pending (pending),
        .valid   (win_valid),
        .id      (win_id),
        .grant   (win_grant)
    );

    assign int_disable = int_cmd & (int_mode == INT_DISABLE);
    assign int_enable  = int_cmd & (int_mode == INT_ENABLE);
    assign int_trigger = int_cmd & (int_mode == INT_TRIGGER);

    // Out-of-range TRIGGER selects produce an empty mask.
    always_comb begin
        trig_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            trig_mask[i] = (int_sel == 3'(i));
        end
    end

`ifdef IRQ_NEST_EN
    // Preemption only from the first level, by a strictly higher priority,
    // and never in the same boundary as a RETURN.
    assign can_vector = (state_q == IDLE) |
                        ((state_q == ISR) & ~nest_q & ~return_cmd &
                         (win_id < active_irq_q));
`else
    assign can_vector = (state_q == IDLE);
`endif

    assign vector_taken  = clk_en & can_vector & int_enabled_q & win_valid & ~int_disable;
    assign return_taken  = clk_en & (state_q == ISR) & return_cmd;
    assign irq_vector_pc = win_valid ? vec_addr(VECTOR_BASE, 16'(VECTOR_STRIDE), win_id) : 16'h0000;
    assign irq_ack       = vector_taken ? win_grant : '0;
    assign return_pc     = saved_pc_q;
    assign int_enabled   = int_enabled_q;
    assign in_isr        = (state_q == ISR);
    assign active_irq    = active_irq_q;

    always_comb begin
        state_d       = state_q;
        int_enabled_d = int_enabled_q;
        sw_pending_d  = sw_pending_q;
        saved_pc_d    = saved_pc_q;
        saved_en_d    = saved_en_q;
        active_irq_d  = active_irq_q;
`ifdef IRQ_NEST_EN
        nest_d        = nest_q;
        stk_pc_d      = stk_pc_q;
        stk_en_d      = stk_en_q;
        stk_irq_d     = stk_irq_q;
`endif
        if (clk_en) begin
            if (vector_taken) begin
`ifdef IRQ_NEST_EN
                if (state_q == ISR) begin
                    nest_d    = 1'b1;
                    stk_pc_d  = saved_pc_q;
                    stk_en_d  = saved_en_q;
                    stk_irq_d = active_irq_q;
                end
`endif
                saved_pc_d    = pc_next_in;
                saved_en_d    = int_enabled_q;
                int_enabled_d = 1'b0;
                active_irq_d  = win_id;
                sw_pending_d  = sw_pending_q & ~win_grant;
                state_d       = ISR;
            end else if (return_taken) begin
                int_enabled_d = saved_en_q;
`ifdef IRQ_NEST_EN
                if (nest_q) begin
                    nest_d       = 1'b0;
                    saved_pc_d   = stk_pc_q;
                    saved_en_d   = stk_en_q;
                    active_irq_d = stk_irq_q;
                end else begin
                    active_irq_d = 3'd0;
                    state_d      = IDLE;
                end
`else
                active_irq_d = 3'd0;
                state_d      = IDLE;
`endif
            end

            // INT commands override the enable restore and the pending clear.
            if (int_disable) begin
                int_enabled_d = 1'b0;
            end else if (int_enable) begin
                int_enabled_d = 1'b1;
            end
            if (int_trigger) begin
                sw_pending_d = sw_pending_d | trig_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            int_enabled_q <= 1'b0;
            sw_pending_q  <= '0;
            saved_pc_q    <= 16'h0000;
            saved_en_q    <= 1'b0;
            active_irq_q  <= 3'd0;
        end else begin
            state_q       <= state_d;
            int_enabled_q <= int_enabled_d;
            sw_pending_q  <= sw_pending_d;
            saved_pc_q    <= saved_pc_d;
            saved_en_q    <= saved_en_d;
            active_irq_q  <= active_irq_d;
        end
    end

`ifdef IRQ_NEST_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nest_q    <= 1'b0;
            stk_pc_q  <= 16'h0000;
            stk_en_q  <= 1'b0;
            stk_irq_q <= 3'd0;
        end else begin
            nest_q    <= nest_d;
            stk_pc_q  <= stk_pc_d;
            stk_en_q  <= stk_en_d;
            stk_irq_q <= stk_irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (default build, NUM_IRQ=4).
module tb_irq_controller;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic [3:0]  irq_req;
    logic        int_cmd;
    logic [1:0]  int_mode;
    logic [2:0]  int_sel;
    logic        return_cmd;
    logic [15:0] pc_next_in;
    logic        vector_taken;
    logic [15:0] irq_vector_pc;
    logic        return_taken;
    logic [15:0] return_pc;
    logic [3:0]  irq_ack;
    logic        int_enabled;
    logic        in_isr;
    logic [2:0]  active_irq;

    irq_controller #(.NUM_IRQ(4), .VECTOR_BASE(16'h0010), .VECTOR_STRIDE(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_en        (clk_en),
        .irq_req       (irq_req),
        .int_cmd       (int_cmd),
        .int_mode      (int_mode),
        .int_sel       (int_sel),
        .return_cmd    (return_cmd),
        .pc_next_in    (pc_next_in),
        .vector_taken  (vector_taken),
        .irq_vector_pc (irq_vector_pc),
        .return_taken  (return_taken),
        .return_pc     (return_pc),
        .irq_ack       (irq_ack),
        .int_enabled   (int_enabled),
        .in_isr        (in_isr),
        .active_irq    (active_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ce;
        logic [3:0]  req;
        logic        cmd;
        logic [1:0]  mode;
        logic [2:0]  sel;
        logic        ret;
        logic [15:0] pcn;
        logic        e_vt;
        logic [15:0] e_vpc;
        logic [3:0]  e_ack;
        logic        e_rt;
        logic [15:0] e_rpc;
        logic        e_en;
        logic        e_isr;
        logic [2:0]  e_act;
    } vec_t;

    localparam logic [1:0] DIS = 2'b00;
    localparam logic [1:0] ENA = 2'b01;
    localparam logic [1:0] TRG = 2'b10;

    int   n_total = 0;
    int   n_pass  = 0;
    vec_t vecs[28];
    vec_t exp_q[$];

    function automatic vec_t mk(logic ce, logic [3:0] req, logic cmd, logic [1:0] mode,
                                logic [2:0] sel, logic ret, logic [15:0] pcn,
                                logic vt, logic [15:0] vpc, logic [3:0] ack,
                                logic rt, logic [15:0] rpc,
                                logic en, logic isr, logic [2:0] act);
        vec_t v;
        v.ce = ce; v.req = req; v.cmd = cmd; v.mode = mode; v.sel = sel;
        v.ret = ret; v.pcn = pcn; v.e_vt = vt; v.e_vpc = vpc; v.e_ack = ack;
        v.e_rt = rt; v.e_rpc = rpc; v.e_en = en; v.e_isr = isr; v.e_act = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        clk_en = 1'b0; irq_req = 4'b0; int_cmd = 1'b0; int_mode = 2'b11;
        int_sel = 3'd0; return_cmd = 1'b0; pc_next_in = 16'h0000;
    endtask

    initial begin
        vec_t v;
        //           ce req     cmd mode sel  ret pcn       vt vpc       ack     rt rpc      en isr act
        vecs[0]  = mk(1, 4'b0000, 1, ENA, 3'd0, 0, 16'h0000, 0, 16'h0000, 4'b0000, 0, 16'h0000, 1, 0, 3'd0);
        vecs[1]  = mk(1, 4'b0100, 0, DIS, 3'd0, 0, 16'h0020, 1, 16'h0018, 4'b0100, 0, 16'h0000, 0, 1, 3'd2);
        vecs[2]  = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h0030, 0, 16'h0000, 4'b0000, 1, 16'h0020, 1, 0, 3'd0);
        vecs[3]  = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h0034, 0, 16'h0000, 4'b0000, 0, 16'h0020, 1, 0, 3'd0);
        vecs[4]  = mk(1, 4'b1010, 0, DIS, 3'd0, 0, 16'h0040, 1, 16'h0014, 4'b0010, 0, 16'h0020, 0, 1, 3'd1);
        vecs[5]  = mk(1, 4'b1010, 0, DIS, 3'd0, 1, 16'h0044, 0, 16'h0000, 4'b0000, 1, 16'h0040, 1, 0, 3'd0);
        vecs[6]  = mk(1, 4'b1000, 0, DIS, 3'd0, 0, 16'h0050, 1, 16'h001C, 4'b1000, 0, 16'h0040, 0, 1, 3'd3);
        vecs[7]  = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h0054, 0, 16'h0000, 4'b0000, 1, 16'h0050, 1, 0, 3'd0);
        vecs[8]  = mk(1, 4'b0000, 1, TRG, 3'd2, 0, 16'h0058, 0, 16'h0000, 4'b0000, 0, 16'h0050, 1, 0, 3'd0);
        vecs[9]  = mk(1, 4'b0000, 0, DIS, 3'd0, 0, 16'h0060, 1, 16'h0018, 4'b0100, 0, 16'h0050, 0, 1, 3'd2);
        vecs[10] = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h0064, 0, 16'h0000, 4'b0000, 1, 16'h0060, 1, 0, 3'd0);
        vecs[11] = mk(1, 4'b0000, 0, DIS, 3'd0, 0, 16'h0070, 0, 16'h0000, 4'b0000, 0, 16'h0060, 1, 0, 3'd0);
        vecs[12] = mk(1, 4'b0001, 1, DIS, 3'd0, 0, 16'h0072, 0, 16'h0000, 4'b0000, 0, 16'h0060, 0, 0, 3'd0);
        vecs[13] = mk(0, 4'b0001, 1, ENA, 3'd0, 1, 16'h0074, 0, 16'h0000, 4'b0000, 0, 16'h0060, 0, 0, 3'd0);
        vecs[14] = mk(1, 4'b0001, 0, DIS, 3'd0, 0, 16'h0076, 0, 16'h0000, 4'b0000, 0, 16'h0060, 0, 0, 3'd0);
        vecs[15] = mk(1, 4'b0001, 1, ENA, 3'd0, 0, 16'h0078, 0, 16'h0000, 4'b0000, 0, 16'h0060, 1, 0, 3'd0);
        vecs[16] = mk(0, 4'b0001, 0, DIS, 3'd0, 0, 16'h007A, 0, 16'h0000, 4'b0000, 0, 16'h0060, 1, 0, 3'd0);
        vecs[17] = mk(1, 4'b0001, 0, DIS, 3'd0, 0, 16'h0080, 1, 16'h0010, 4'b0001, 0, 16'h0060, 0, 1, 3'd0);
        vecs[18] = mk(1, 4'b0001, 1, ENA, 3'd0, 0, 16'h0082, 0, 16'h0000, 4'b0000, 0, 16'h0080, 1, 1, 3'd0);
        vecs[19] = mk(1, 4'b0000, 1, DIS, 3'd0, 1, 16'h0084, 0, 16'h0000, 4'b0000, 1, 16'h0080, 0, 0, 3'd0);
        vecs[20] = mk(1, 4'b0000, 1, ENA, 3'd0, 0, 16'h0086, 0, 16'h0000, 4'b0000, 0, 16'h0080, 1, 0, 3'd0);
        vecs[21] = mk(1, 4'b0000, 1, TRG, 3'd5, 0, 16'h0088, 0, 16'h0000, 4'b0000, 0, 16'h0080, 1, 0, 3'd0);
        vecs[22] = mk(1, 4'b0000, 0, DIS, 3'd0, 0, 16'h008A, 0, 16'h0000, 4'b0000, 0, 16'h0080, 1, 0, 3'd0);
        vecs[23] = mk(1, 4'b0001, 1, TRG, 3'd0, 0, 16'h0090, 1, 16'h0010, 4'b0001, 0, 16'h0080, 0, 1, 3'd0);
        vecs[24] = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h0094, 0, 16'h0000, 4'b0000, 1, 16'h0090, 1, 0, 3'd0);
        vecs[25] = mk(1, 4'b0000, 0, DIS, 3'd0, 0, 16'h00A0, 1, 16'h0010, 4'b0001, 0, 16'h0090, 0, 1, 3'd0);
        vecs[26] = mk(1, 4'b0000, 0, DIS, 3'd0, 1, 16'h00A4, 0, 16'h0000, 4'b0000, 1, 16'h00A0, 1, 0, 3'd0);
        vecs[27] = mk(1, 4'b0000, 0, DIS, 3'd0, 0, 16'h00A8, 0, 16'h0000, 4'b0000, 0, 16'h00A0, 1, 0, 3'd0);

        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        chk("reset vector_taken", 32'(vector_taken), 32'd0);
        chk("reset irq_vector_pc", 32'(irq_vector_pc), 32'd0);
        chk("reset return_taken", 32'(return_taken), 32'd0);
        chk("reset return_pc", 32'(return_pc), 32'd0);
        chk("reset irq_ack", 32'(irq_ack), 32'd0);
        chk("reset int_enabled", 32'(int_enabled), 32'd0);
        chk("reset in_isr", 32'(in_isr), 32'd0);
        chk("reset active_irq", 32'(active_irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            clk_en = vecs[i].ce; irq_req = vecs[i].req; int_cmd = vecs[i].cmd;
            int_mode = vecs[i].mode; int_sel = vecs[i].sel; return_cmd = vecs[i].ret;
            pc_next_in = vecs[i].pcn;
            exp_q.push_back(vecs[i]);
            #2;
            v = exp_q.pop_front();
            chk($sformatf("row%0d vector_taken", i), 32'(vector_taken), 32'(v.e_vt));
            if (v.e_vt) chk($sformatf("row%0d irq_vector_pc", i), 32'(irq_vector_pc), 32'(v.e_vpc));
            chk($sformatf("row%0d irq_ack", i), 32'(irq_ack), 32'(v.e_ack));
            chk($sformatf("row%0d return_taken", i), 32'(return_taken), 32'(v.e_rt));
            chk($sformatf("row%0d return_pc", i), 32'(return_pc), 32'(v.e_rpc));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d int_enabled", i), 32'(int_enabled), 32'(v.e_en));
            chk($sformatf("row%0d in_isr", i), 32'(in_isr), 32'(v.e_isr));
            chk($sformatf("row%0d active_irq", i), 32'(active_irq), 32'(v.e_act));
        end

        // Asynchronous reset between edges while in an ISR.
        @(negedge clk);
        idle_inputs();
        clk_en = 1'b1; irq_req = 4'b0100; pc_next_in = 16'h00B0;
        @(posedge clk);
        #1;
        chk("mid-isr entered in_isr", 32'(in_isr), 32'd1);
        chk("mid-isr active_irq", 32'(active_irq), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset in_isr", 32'(in_isr), 32'd0);
        chk("async reset int_enabled", 32'(int_enabled), 32'd0);
        chk("async reset active_irq", 32'(active_irq), 32'd0);
        chk("async reset return_pc", 32'(return_pc), 32'd0);
        chk("async reset vector_taken", 32'(vector_taken), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        irq_req = 4'b0000; return_cmd = 1'b1; clk_en = 1'b1;
        #2;
        chk("return after reset return_taken", 32'(return_taken), 32'd0);
        @(posedge clk);
        #1;
        chk("return after reset in_isr", 32'(in_isr), 32'd0);
        chk("return after reset int_enabled", 32'(int_enabled), 32'd0);

        @(negedge clk);
        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
